// File: rtl/decode_scan_n.sv
// -----------------------------------------------------------------------------
// decode_scan_n
//
// Registered, parametrised active-low decoder with an auto-scan mode.
// It sits between a display/bus controller and a set of digit enables or
// chip selects.
//
//   mode = 0 (direct) : y_n[sel] goes low one clock after sel is presented.
//   mode = 1 (scan)   : a prescaled counter walks the low strobe across
//                       outputs 0..scan_last. Each output is held for
//                       SCAN_DIV clocks.
//
// Parameters
//   SEL_W     : select width. The output count is OUT_N = 2**SEL_W.
//   SCAN_DIV  : clocks per scan step (>= 1).
//   BLANK_CYC : dead-time clocks at the start of each scan step
//               (1..SCAN_DIV-1). It only has an effect when the
//               DECODE_SCAN_BLANKING_EN macro is defined.
//
// Optional feature (macro DECODE_SCAN_BLANKING_EN)
//   When this macro is defined, y_n is forced to all ones in scan mode while
//   the prescaler is below BLANK_CYC. This gives ghosting dead time after
//   every step. idx and step timing do not change, and direct mode is not
//   affected.
//
// Ports
//   clk       in  1      rising-edge clock
//   rst_n     in  1      synchronous reset, active-low
//   g1        in  1      enable, active-high
//   g2_n      in  1      enable, active-low
//   g3_n      in  1      enable, active-low
//   mode      in  1      0 = direct decode, 1 = auto-scan
//   sel       in  SEL_W  select used in direct mode
//   scan_last in  SEL_W  highest index visited in scan mode
//   y_n       out OUT_N  registered outputs, one-hot-low or all ones
//   idx       out SEL_W  index currently driven (scan) or last sel (direct)
//   step      out 1      one-clock pulse when idx advances in scan mode
//
// Handshake: there is no valid/ready pair. Inputs are sampled on every rising
// edge, and every output is a register that updates on that same edge.
// -----------------------------------------------------------------------------
module decode_scan_n #(
  parameter int SEL_W     = 3,
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  g1,
  input  logic                  g2_n,
  input  logic                  g3_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [SEL_W-1:0]      scan_last,
  output logic [2**SEL_W-1:0]   y_n,
  output logic [SEL_W-1:0]      idx,
  output logic                  step
);

  localparam int OUT_N = 2**SEL_W;

  // The prescaler needs at least one bit, even when SCAN_DIV = 1.
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

`ifdef DECODE_SCAN_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] presc;   // position inside the current scan step
  logic             mode_q;  // mode from the previous clock; used to detect scan entry

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             en;
  logic             at_step;    // the prescaler is at its last count
  logic             scan_wrap;  // the next step returns to index 0
  logic [SEL_W-1:0] idx_next;   // index after the next step
  logic [PRE_W-1:0] presc_inc;

  // Builds a one-hot-low strobe for index s.
  function automatic logic [OUT_N-1:0] strobe_n(input logic [SEL_W-1:0] s);
    logic [OUT_N-1:0] r;
    r    = '1;
    r[s] = 1'b0;
    return r;
  endfunction

  // Returns 1 when the prescaler value p falls inside the dead-time window.
  // When blanking is compiled out, BLANK_EN is 0 and this folds to 0.
  function automatic logic blanked(input logic [PRE_W-1:0] p);
    return BLANK_EN && (int'(p) < BLANK_CYC);
  endfunction

  always_comb begin
    en        = g1 & ~g2_n & ~g3_n;
    at_step   = (presc == PRE_LAST);
    // The wrap uses >= rather than ==. If scan_last shrinks below the current
    // idx, the next step goes to 0 instead of running up to OUT_N-1.
    scan_wrap = (idx >= scan_last);
    idx_next  = scan_wrap ? '0 : idx + SEL_W'(1);
    presc_inc = presc + PRE_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Registered datapath
  // Priority: reset > disable > direct decode > scan entry > scan run.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_n    <= '1;
      idx    <= '0;
      step   <= 1'b0;
      presc  <= '0;
      mode_q <= 1'b0;
    end else begin
      // mode_q tracks mode even while disabled. If mode rises while the
      // block is disabled, re-enabling resumes the scan and does not restart it.
      mode_q <= mode;

      if (!en) begin
        // idx and the prescaler hold their values, so a later re-enable
        // continues exactly where the scan stopped.
        y_n  <= '1;
        step <= 1'b0;
      end else if (!mode) begin
        y_n   <= strobe_n(sel);
        idx   <= sel;
        presc <= '0;
        step  <= 1'b0;
      end else if (!mode_q) begin
        // First scan clock after direct mode (or after reset): restart at 0.
        idx   <= '0;
        presc <= '0;
        step  <= 1'b0;
        y_n   <= blanked('0) ? '1 : strobe_n('0);
      end else if (at_step) begin
        // When SCAN_DIV = 1, PRE_LAST is 0, so this branch runs every clock
        // and step stays high.
        idx   <= idx_next;
        presc <= '0;
        step  <= 1'b1;
        y_n   <= blanked('0) ? '1 : strobe_n(idx_next);
      end else begin
        presc <= presc_inc;
        step  <= 1'b0;
        y_n   <= blanked(presc_inc) ? '1 : strobe_n(idx);
      end
    end
  end

endmodule

// File: tb/tb_decode_scan_n.sv
// -----------------------------------------------------------------------------
// tb_decode_scan_n
//
// Self-checking bench for decode_scan_n with SEL_W=3, SCAN_DIV=4, BLANK_CYC=1.
// The bench is organised as follows:
//   - clock and reset block
//   - driver tasks
//   - behavioural reference model and a scoreboard queue (exp_q)
//   - a table of directed vectors
//   - hand-written multi-cycle sequences
//   - randomised traffic
//   - a final report line
//
// If DECODE_SCAN_BLANKING_EN is defined for the build, the reference model and
// the hand-written expectations add the one-clock dead time.
// -----------------------------------------------------------------------------
module tb_decode_scan_n;

  localparam int SEL_W     = 3;
  localparam int OUT_N     = 8;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int EW        = OUT_N + SEL_W + 1;

`ifdef DECODE_SCAN_BLANKING_EN
  localparam int TB_BLANK = BLANK_CYC;
`else
  localparam int TB_BLANK = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             g1, g2_n, g3_n, mode;
  logic [SEL_W-1:0] sel, scan_last;
  logic [OUT_N-1:0] y_n;
  logic [SEL_W-1:0] idx;
  logic             step;

  decode_scan_n #(
    .SEL_W    (SEL_W),
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g1       (g1),
    .g2_n     (g2_n),
    .g3_n     (g3_n),
    .mode     (mode),
    .sel      (sel),
    .scan_last(scan_last),
    .y_n      (y_n),
    .idx      (idx),
    .step     (step)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. It tracks the scan position as a count of clocks since
  // the last step, modulo SCAN_DIV. The strobe is computed arithmetically.
  // ---------------------------------------------------------------------------
  int m_idx  = 0;
  int m_cnt  = 0;
  bit m_mode = 0;
  bit m_step = 0;
  int m_y    = 255;

  function automatic int strobe_val(input int i);
    return ((1 << OUT_N) - 1) - (1 << i);
  endfunction

  task automatic model_clock();
    bit m_en;
    m_en = g1 && !g2_n && !g3_n;
    if (!rst_n) begin
      m_idx = 0; m_cnt = 0; m_mode = 0; m_step = 0; m_y = (1 << OUT_N) - 1;
      return;
    end
    if (!m_en) begin
      m_y    = (1 << OUT_N) - 1;
      m_step = 0;
    end else if (!mode) begin
      m_idx  = int'(sel);
      m_cnt  = 0;
      m_step = 0;
      m_y    = strobe_val(m_idx);
    end else begin
      if (!m_mode) begin
        m_idx  = 0;
        m_cnt  = 0;
        m_step = 0;
      end else begin
        m_cnt  = (m_cnt + 1) % SCAN_DIV;
        m_step = (m_cnt == 0);
        if (m_step) m_idx = (m_idx >= int'(scan_last)) ? 0 : m_idx + 1;
      end
      m_y = (m_cnt < TB_BLANK) ? (1 << OUT_N) - 1 : strobe_val(m_idx);
    end
    m_mode = mode;
  endtask

  // ---------------------------------------------------------------------------
  // Driver: advance one clock, check against the model, and check the
  // one-hot-low invariant. Inputs are driven 1 time unit after the rising
  // edge, and outputs are sampled at that same point.
  // ---------------------------------------------------------------------------
  task automatic tick();
    logic [EW-1:0] e;
    model_clock();
    exp_q.push_back({OUT_N'(m_y), SEL_W'(m_idx), m_step});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("model_y_n",  32'(y_n),  32'(e[EW-1 -: OUT_N]));
    check("model_idx",  32'(idx),  32'(e[SEL_W:1]));
    check("model_step", 32'(step), 32'(e[0]));
    check("one_hot_low", 32'($countones(~y_n) <= 1), 32'(1));
  endtask

  task automatic drive(input logic r, input logic a, input logic b, input logic c,
                       input logic m, input logic [SEL_W-1:0] s,
                       input logic [SEL_W-1:0] l);
    rst_n = r; g1 = a; g2_n = b; g3_n = c; mode = m; sel = s; scan_last = l;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 3'd7);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             rst_n, g1, g2_n, g3_n, mode;
    logic [SEL_W-1:0] sel, last;
    logic [OUT_N-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             step;
  } vec_t;

  vec_t vecs[10];
  logic [OUT_N-1:0] entry_y;
  logic [OUT_N-1:0] pat3[3];
  logic [OUT_N-1:0] pat2[2];
  logic [OUT_N-1:0] ey;

  initial begin
    entry_y = (TB_BLANK > 0) ? 8'hFF : 8'hFE;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 8'hFF, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, 8'hFF, 3'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd7, entry_y, 3'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd7, 8'hDF, 3'd5, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 8'hFE, 3'd0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd7, 8'hFF, 3'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 3'd7, 8'hFF, 3'd0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'h7F, 3'd7, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd7, 8'hFF, 3'd7, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 8'hFB, 3'd2, 1'b0};
    pat3[0] = 8'hFE; pat3[1] = 8'hFD; pat3[2] = 8'hFB;
    pat2[0] = 8'hFE; pat2[1] = 8'hFD;

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd7);
    #1;

    // Reset, direct decode, and enable gating.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst_n, vecs[i].g1, vecs[i].g2_n, vecs[i].g3_n,
            vecs[i].mode, vecs[i].sel, vecs[i].last);
      tick();
      check($sformatf("vec%0d_y_n", i),  32'(y_n),  32'(vecs[i].y));
      check($sformatf("vec%0d_idx", i),  32'(idx),  32'(vecs[i].idx));
      check($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].step));
    end

    // Scan with wrap at scan_last = 2.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd2);
    for (int k = 0; k < 16; k++) begin
      tick();
      ey = (k % 4 < TB_BLANK) ? 8'hFF : pat3[(k / 4) % 3];
      check("scan_wrap_y_n", 32'(y_n), 32'(ey));
      check("scan_wrap_idx", 32'(idx), 32'((k / 4) % 3));
      check("scan_wrap_step", 32'(step), 32'((k % 4 == 0) && (k > 0)));
    end

    // scan_last shrinks below the current idx.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd7);
    for (int k = 0; k < 26; k++) tick();
    check("shrink_pre_idx", 32'(idx), 32'd6);
    scan_last = 3'd3;
    tick(); tick();
    check("shrink_hold_idx", 32'(idx), 32'd6);
    tick();
    check("shrink_wrap_idx", 32'(idx), 32'd0);
    check("shrink_wrap_step", 32'(step), 32'd1);
    check("shrink_wrap_y_n", 32'(y_n), 32'(entry_y));
    for (int k = 0; k < 20; k++) begin
      tick();
      check("shrink_upper_quiet", 32'(y_n[7:4]), 32'hF);
    end

    // Disable in the middle of a scan, then toggle the mode.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd7);
    for (int k = 0; k < 18; k++) tick();
    g1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dis_y_n", 32'(y_n), 32'hFF);
      check("dis_idx", 32'(idx), 32'd4);
      check("dis_step", 32'(step), 32'd0);
    end
    g1 = 1'b1;
    tick();
    check("resume1_y_n", 32'(y_n), 32'hEF);
    check("resume1_step", 32'(step), 32'd0);
    tick();
    check("resume2_step", 32'(step), 32'd0);
    tick();
    check("resume3_step", 32'(step), 32'd1);
    check("resume3_idx", 32'(idx), 32'd5);
    mode = 1'b0; sel = 3'd3;
    tick();
    check("toggle_direct_y_n", 32'(y_n), 32'hF7);
    mode = 1'b1;
    tick();
    check("toggle_entry_idx", 32'(idx), 32'd0);
    check("toggle_entry_y_n", 32'(y_n), 32'(entry_y));
    check("toggle_entry_step", 32'(step), 32'd0);

    // Two-index scan; with blanking this shows the dead-time clock.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd1);
    for (int k = 0; k < 16; k++) begin
      tick();
      ey = (k % 4 < TB_BLANK) ? 8'hFF : pat2[(k / 4) % 2];
      check("blank_y_n", 32'(y_n), 32'(ey));
    end

    // Randomised traffic checked against the model.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, '0, 3'd5);
    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      g1    = ($urandom_range(0, 9) != 0);
      g2_n  = ($urandom_range(0, 14) == 0);
      g3_n  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      sel = SEL_W'($urandom_range(0, OUT_N - 1));
      if ($urandom_range(0, 29) == 0) scan_last = SEL_W'($urandom_range(0, OUT_N - 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
